seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_hex_decode.sv | 33 +++
 rtl/seg7_scan_driver.sv | 106 ++++++++++
 tb/tb_seg7_scan_driver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the 7-segment scan driver.
// Segment order is a..g with a in the MSB, active-high.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1111011;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder.
// Lowercase glyphs are used for b and d.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  // Full 16-entry lookup of the glyph table
  always_comb begin
    seg_o = SEG_0;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous value loads.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  output seg_t                    seg_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_done_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         shadow;
  logic [VW-1:0]         pending;
  logic                  tc;
  logic                  boundary;
  logic                  accept;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] sel_d;
  logic                  blank;
  seg_t                  dec;

  assign tc       = (cnt == CNT_LAST);
  assign boundary = tc && (idx == IDX_LAST);
  assign accept   = load_valid_i && load_ready_o;

  // Refresh counter and digit index advance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (tc) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Load handshake: boundary loads bypass pending
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow       <= '0;
      pending      <= '0;
      load_ready_o <= 1'b1;
    end else if (accept && boundary) begin
      shadow <= value_i;
    end else if (accept) begin
      pending      <= value_i;
      load_ready_o <= 1'b0;
    end else if (boundary && !load_ready_o) begin
      shadow       <= pending;
      load_ready_o <= 1'b1;
    end
  end

  // Pick current nibble, one-hot select and blanking
  always_comb begin
    nib   = '0;
    sel_d = '0;
    blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib      = shadow[4*i +: 4];
        sel_d[i] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank    = (i != 0) && ((shadow >> (4*i)) == '0);
`endif
      end
    end
  end

  seg7_hex_decode u_dec (
    .hex_i (nib),
    .seg_o (dec)
  );

  // Registered display outputs and frame pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_o        <= '0;
      digit_sel_o  <= '0;
      frame_done_o <= 1'b0;
    end else begin
      seg_o        <= (enable_i && !blank) ? dec : '0;
      digit_sel_o  <= enable_i ? sel_d : '0;
      frame_done_o <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver, 4 digits, 4-cycle refresh.
// Expected frames are queued on load and compared frame by frame.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] value;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]     val;
    logic            en;
    int              load_at;
    logic [3:0][6:0] seg;
  } rec_t;

  localparam logic [6:0] Z = 7'b1111110;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] B = 7'b0000000;
`else
  localparam logic [6:0] B = Z;
`endif

  rec_t tbl[7];
  rec_t zero_rec;
  rec_t sbq[$];

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .value_i      (value),
    .seg_o        (seg),
    .digit_sel_o  (digit_sel),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h",
               name, $time, act, exp);
    end
  endtask

  // Called in the frame_done cycle; checks the 16 following cycles.
  task automatic frame(input rec_t r, input int load_at,
                       input rec_t nxt);
    int d;
    enable = r.en;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      d = (j - 1) / 4;
      chk("digit_sel", 32'(digit_sel), r.en ? (32'd1 << d) : 32'd0);
      chk("seg", 32'(seg), r.en ? 32'(r.seg[d]) : 32'd0);
      chk("frame_done", 32'(frame_done), 32'(j == 16));
      if (load_valid) begin
        load_valid = 1'b0;
        value      = 16'($urandom);
        if (load_at < 15)
          chk("ready_drop", 32'(load_ready), 32'd0);
      end
      if (j == load_at) begin
        chk("ready_before_load", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        value      = nxt.val;
        sbq.push_back(nxt);
      end
      if (load_at >= 0 && load_at < 15 && j == load_at + 3) begin
        load_valid = 1'b1;
        value      = 16'hFFFF;
      end
      if (j == 16 && load_at >= 0)
        chk("ready_at_frame", 32'(load_ready), 32'd1);
    end
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    rec_t r;
    rec_t nxt;
    int   la;

    zero_rec = '{val:16'h0000, en:1'b1, load_at:15, seg:{B, B, B, Z}};
    tbl[0] = '{val:16'h1234, en:1'b1, load_at:15,
               seg:{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
    tbl[1] = '{val:16'hABCD, en:1'b1, load_at:5,
               seg:{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101}};
    tbl[2] = '{val:16'h5678, en:1'b1, load_at:15,
               seg:{7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}};
    tbl[3] = '{val:16'h0070, en:1'b1, load_at:5,
               seg:{B, B, 7'b1110000, Z}};
    tbl[4] = '{val:16'h9EF0, en:1'b0, load_at:5,
               seg:{7'h00, 7'h00, 7'h00, 7'h00}};
    tbl[5] = '{val:16'h0001, en:1'b1, load_at:5,
               seg:{B, B, B, 7'b0110000}};
    tbl[6] = '{val:16'h0000, en:1'b1, load_at:15,
               seg:{B, B, B, Z}};

    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    value      = '0;
    #1;
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_sel", 32'(digit_sel), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;

    wait_frame("first_frame");
    frame(zero_rec, tbl[0].load_at, tbl[0]);
    for (int i = 0; i < 7; i++) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty idx=%0d", i);
        r = zero_rec;
      end else begin
        r = sbq.pop_front();
      end
      nxt = (i < 6) ? tbl[i+1] : tbl[i];
      la  = (i < 6) ? tbl[i+1].load_at : -1;
      frame(r, la, nxt);
    end

    enable = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 5) begin
        load_valid = 1'b1;
        value      = 16'h8888;
      end
      if (j == 6) begin
        load_valid = 1'b0;
        chk("pend_before_rst", 32'(load_ready), 32'd0);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg), 32'd0);
    chk("async_rst_sel", 32'(digit_sel), 32'd0);
    chk("async_rst_fd", 32'(frame_done), 32'd0);
    chk("async_rst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_frame("frame_after_rst");
    frame(zero_rec, -1, zero_rec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
